// File: rtl/fifo_ptr_ctrl_256x256.sv
// Pointer, occupancy and status-flag controller for the 256x256 pixel FIFO of the median filter.
// Latency: pointers/count/flags update on the strobe edge (visible next cycle); rd_valid 1 cycle after an accepted read.
// Backpressure: writes into a full FIFO and reads from an empty FIFO are dropped and recorded in sticky error flags.
module fifo_ptr_ctrl_256x256 #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          AFULL_TH   = 65520,
  parameter int          AEMPTY_TH  = 16,
  parameter int unsigned FRAME_PIX  = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ff_clr,
  input  logic                  ff_en,
  input  logic                  ff_push_pop,
  input  logic                  ff_we,
  input  logic                  ff_re,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   ff_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  rd_valid,
  output logic                  ovf_err,
  output logic                  udf_err,
  output logic                  frame_done
);

  // Pointer/count width includes the wrap bit so that "full" (count = depth) is representable.
  localparam int               PW         = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]    PTR_ONE    = PW'(1);
  localparam logic [PW-1:0]    AFULL_C    = PW'(AFULL_TH);
  localparam logic [PW-1:0]    AEMPTY_C   = PW'(AEMPTY_TH);
  localparam logic [31:0]      FRAME_LAST = 32'(FRAME_PIX - 1);

  logic        full;
  logic        empty;
  logic        wr_ok;
  logic        rd_ok;
  logic        flush;
  logic        push_req;
  logic        pop_req;
  logic [31:0] frame_cnt;

  // Full/empty are derived only from our own registered pointers, never from the strobes' source,
  // so an ill-gated strobe from the status logic cannot corrupt the pointers.
  assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign empty = (wptr == rptr);

  // Strobes that would overrun or underrun the RAM are silently ignored.
  assign wr_ok = ff_we & ~full;
  assign rd_ok = ff_re & ~empty;

  // rst and ff_clr have identical effect on every register; rst only wins in priority by name.
  assign flush = rst | ff_clr;

  // Raw requests are watched as well as qualified strobes so that a misbehaving producer or
  // consumer is flagged even when the status logic already masked its strobe.
  assign push_req = ff_en &  ff_push_pop;
  assign pop_req  = ff_en & ~ff_push_pop;

  // RAM addresses are the pointers without their wrap bit.
  assign waddr = wptr[ADDR_WIDTH-1:0];
  assign raddr = rptr[ADDR_WIDTH-1:0];

  // Watermarks are pure compares on the registered count, so they add no pipeline stage.
  assign almost_full  = (ff_count >= AFULL_C);
  assign almost_empty = (ff_count <= AEMPTY_C);

  // Write and read pointers advance on accepted strobes; the wrap bit toggles naturally on rollover.
  always_ff @(posedge clk) begin
    if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Occupancy tracks wptr - rptr incrementally; a simultaneous write and read leave it unchanged.
  always_ff @(posedge clk) begin
    if (flush) begin
      ff_count <= '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   ff_count <= ff_count + PTR_ONE;
        2'b01:   ff_count <= ff_count - PTR_ONE;
        default: ff_count <= ff_count;
      endcase
    end
  end

  // Read data appears one cycle after the address, matching the synchronous RAM; a flush drops it.
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
    end
  end

  // Sticky overflow/underflow flags, cleared only by rst or ff_clr.
  always_ff @(posedge clk) begin
    if (flush) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if ((push_req | ff_we) & full) begin
        ovf_err <= 1'b1;
      end
      if ((pop_req | ff_re) & empty) begin
        udf_err <= 1'b1;
      end
    end
  end

  // Count accepted reads per frame and pulse frame_done for one cycle after the last pixel.
  always_ff @(posedge clk) begin
    if (flush) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (rd_ok && (frame_cnt == FRAME_LAST)) begin
      frame_cnt  <= '0;
      frame_done <= 1'b1;
    end else begin
      if (rd_ok) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl_256x256.sv
module tb_fifo_ptr_ctrl_256x256;

  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;
  localparam int FPIX = 16;

  logic          clk;
  logic          rst;
  logic          ff_clr;
  logic          ff_en;
  logic          ff_push_pop;
  logic          ff_we;
  logic          ff_re;
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [AW:0]   ff_count;
  logic          almost_full;
  logic          almost_empty;
  logic          rd_valid;
  logic          ovf_err;
  logic          udf_err;
  logic          frame_done;

  fifo_ptr_ctrl_256x256 #(
    .ADDR_WIDTH(AW),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH),
    .FRAME_PIX (FPIX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ff_clr      (ff_clr),
    .ff_en       (ff_en),
    .ff_push_pop (ff_push_pop),
    .ff_we       (ff_we),
    .ff_re       (ff_re),
    .wptr        (wptr),
    .rptr        (rptr),
    .waddr       (waddr),
    .raddr       (raddr),
    .ff_count    (ff_count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .rd_valid    (rd_valid),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [AW:0]   cnt;
    logic          af;
    logic          ae;
    logic          rdv;
    logic          ovf;
    logic          udf;
    logic          fd;
  } snap_t;

  snap_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: occupancy as an integer, pointers as free-running integers.
  int m_occ = 0;
  int m_wp = 0;
  int m_rp = 0;
  int m_fc = 0;
  bit m_rdv = 0;
  bit m_ovf = 0;
  bit m_udf = 0;
  bit m_fd = 0;

  function automatic snap_t sample();
    snap_t s;
    s.wptr = wptr; s.rptr = rptr; s.waddr = waddr; s.raddr = raddr;
    s.cnt = ff_count; s.af = almost_full; s.ae = almost_empty;
    s.rdv = rd_valid; s.ovf = ovf_err; s.udf = udf_err; s.fd = frame_done;
    return s;
  endfunction

  // Drive one cycle of stimulus, advance the model, push the expected post-edge state.
  task automatic cyc(input bit r, input bit c, input bit en, input bit pp, input bit we, input bit re);
    snap_t e;
    bit wr;
    bit rd;
    @(negedge clk);
    rst = r; ff_clr = c; ff_en = en; ff_push_pop = pp; ff_we = we; ff_re = re;
    if (r || c) begin
      m_occ = 0; m_wp = 0; m_rp = 0; m_fc = 0;
      m_rdv = 0; m_ovf = 0; m_udf = 0; m_fd = 0;
    end else begin
      wr = we && (m_occ != DEPTH);
      rd = re && (m_occ != 0);
      if (((en && pp) || we) && m_occ == DEPTH) m_ovf = 1;
      if (((en && !pp) || re) && m_occ == 0) m_udf = 1;
      if (wr) begin m_wp = (m_wp + 1) % (2 * DEPTH); m_occ++; end
      if (rd) begin m_rp = (m_rp + 1) % (2 * DEPTH); m_occ--; end
      m_rdv = rd;
      m_fd = 0;
      if (rd) begin
        m_fc++;
        if (m_fc == FPIX) begin m_fc = 0; m_fd = 1; end
      end
    end
    e.wptr = 5'(m_wp); e.rptr = 5'(m_rp);
    e.waddr = 4'(m_wp % DEPTH); e.raddr = 4'(m_rp % DEPTH);
    e.cnt = 5'(m_occ); e.af = (m_occ >= AF_TH); e.ae = (m_occ <= AE_TH);
    e.rdv = m_rdv; e.ovf = m_ovf; e.udf = m_udf; e.fd = m_fd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      checks++;
      if (sample() !== e) begin
        errors++; $display("FAIL reset[%0d] got=%h exp=%h", i, sample(), e);
      end
    end
    cyc(0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if ({wptr, rptr, ff_count, almost_empty, almost_full, rd_valid, ovf_err, udf_err, frame_done} !== {5'd0, 5'd0, 5'd0, 6'b100000}) begin
      errors++; $display("FAIL reset_vals got w=%h r=%h c=%h ae=%b af=%b", wptr, rptr, ff_count, almost_empty, almost_full);
    end
  endtask

  task automatic test_fill();
    snap_t e;
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1, 1, 1, 0);
      e = sb.pop_front();
      checks++;
      if (sample() !== e) begin
        errors++; $display("FAIL fill[%0d] got=%h exp=%h", i, sample(), e);
      end
      if (i == 13 || i == 14) begin
        checks++;
        if (almost_full !== (i == 14)) begin
          errors++; $display("FAIL fill_afull count=%0d got=%b exp=%b", i, almost_full, (i == 14));
        end
      end
    end
    checks++;
    if ({ff_count, wptr, waddr} !== {5'd16, 5'b10000, 4'd0}) begin
      errors++; $display("FAIL fill_full got c=%h w=%h wa=%h exp c=10 w=10 wa=0", ff_count, wptr, waddr);
    end
    cyc(0, 0, 1, 1, 1, 0);
    e = sb.pop_front();
    checks++;
    if (sample() !== e || wptr !== 5'b10000 || ovf_err !== 1'b1) begin
      errors++; $display("FAIL fill_ovf got w=%h ovf=%b exp w=10 ovf=1", wptr, ovf_err);
    end
  endtask

  task automatic test_drain();
    snap_t e;
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1, 0, 0, 1);
      e = sb.pop_front();
      checks++;
      if (sample() !== e || rd_valid !== 1'b1 || frame_done !== (i == 16)) begin
        errors++; $display("FAIL drain[%0d] got=%h exp=%h rdv=%b fd=%b", i, sample(), e, rd_valid, frame_done);
      end
    end
    checks++;
    if ({rptr, ff_count} !== {5'b10000, 5'd0}) begin
      errors++; $display("FAIL drain_end got r=%h c=%h exp r=10 c=0", rptr, ff_count);
    end
    cyc(0, 0, 1, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (sample() !== e || udf_err !== 1'b1 || rptr !== 5'b10000 || rd_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL drain_udf got=%h exp=%h", sample(), e);
    end
  endtask

  task automatic test_simultaneous();
    snap_t e;
    cyc(0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      void'(sb.pop_front());
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      e = sb.pop_front();
      checks++;
      if (sample() !== e || ff_count !== 5'd5 || rd_valid !== 1'b1 || wptr !== 5'(5 + i) || rptr !== 5'(i)) begin
        errors++; $display("FAIL simul[%0d] got=%h exp=%h", i, sample(), e);
      end
    end
  endtask

  task automatic test_wrap();
    snap_t e;
    cyc(0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 1, 1, 1, 0);
      e = sb.pop_front();
      checks++;
      if (sample() !== e || ff_count > 5'd1 || ovf_err || udf_err) begin
        errors++; $display("FAIL wrap_wr[%0d] got=%h exp=%h", i, sample(), e);
      end
      if (i == 16 || i == 32) begin
        checks++;
        if (wptr[AW] !== (i == 16)) begin
          errors++; $display("FAIL wrap_msb after %0d got=%b exp=%b", i, wptr[AW], (i == 16));
        end
      end
      cyc(0, 0, 1, 0, 0, 1);
      e = sb.pop_front();
      checks++;
      if (sample() !== e || ff_count !== 5'd0 || ovf_err || udf_err) begin
        errors++; $display("FAIL wrap_rd[%0d] got=%h exp=%h", i, sample(), e);
      end
    end
    checks++;
    if ({wptr, rptr} !== {5'b01000, 5'b01000}) begin
      errors++; $display("FAIL wrap_end got w=%h r=%h exp w=08 r=08", wptr, rptr);
    end
  endtask

  task automatic test_clear();
    snap_t e;
    cyc(0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      void'(sb.pop_front());
    end
    checks++;
    if ({ff_count, ovf_err} !== {5'd9, 1'b1}) begin
      errors++; $display("FAIL clear_pre got c=%h ovf=%b exp c=09 ovf=1", ff_count, ovf_err);
    end
    cyc(0, 1, 1, 1, 1, 0);
    e = sb.pop_front();
    checks++;
    if (sample() !== e || {wptr, rptr, ff_count, ovf_err, almost_empty} !== {15'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL clear got=%h exp=%h", sample(), e);
    end
    // Reset arriving with an accepted read in the same cycle must drop rd_valid.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      void'(sb.pop_front());
    end
    cyc(1, 0, 0, 0, 0, 1);
    e = sb.pop_front();
    checks++;
    if (sample() !== e || rd_valid !== 1'b0 || ff_count !== 5'd0) begin
      errors++; $display("FAIL rst_inflight got=%h exp=%h", sample(), e);
    end
  endtask

  initial begin
    rst = 1'b1; ff_clr = 1'b0; ff_en = 1'b0; ff_push_pop = 1'b0; ff_we = 1'b0; ff_re = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl_256x256.md
Name: fifo_ptr_ctrl_256x256

Overview:
Pointer and occupancy controller for the 256x256 pixel FIFO in the median-filter datapath. It owns the registered write/read pointers that feed the FIFO status-signal logic, and consumes that logic's ff_we/ff_re qualified strobes. It drives the RAM write/read addresses, occupancy count, almost-full/almost-empty flags, read-data-valid, sticky over/underflow flags and an end-of-frame pulse.

Parameters:
ADDR_WIDTH, 16, FIFO address bits; depth = 2^ADDR_WIDTH; pointers carry one extra wrap bit.
AFULL_TH, 65520, almost_full asserts when ff_count >= AFULL_TH.
AEMPTY_TH, 16, almost_empty asserts when ff_count <= AEMPTY_TH.
FRAME_PIX, 65536, reads per frame (256*256); range 1..2^32-1.

Ports:
clk  input  1  single clock, all state on rising edge.
rst  input  1  synchronous, active-high reset.
ff_clr  input  1  synchronous flush; same effect as rst on all state.
ff_en  input  1  FIFO enable (raw request).
ff_push_pop  input  1  1 = push request, 0 = pop request (raw).
ff_we  input  1  qualified write strobe from status logic.
ff_re  input  1  qualified read strobe from status logic.
wptr  output  ADDR_WIDTH+1  registered write pointer, MSB = wrap bit.
rptr  output  ADDR_WIDTH+1  registered read pointer, MSB = wrap bit.
waddr  output  ADDR_WIDTH  = wptr[ADDR_WIDTH-1:0], RAM write address.
raddr  output  ADDR_WIDTH  = rptr[ADDR_WIDTH-1:0], RAM read address.
ff_count  output  ADDR_WIDTH+1  registered occupancy, 0..2^ADDR_WIDTH.
almost_full  output  1  ff_count >= AFULL_TH.
almost_empty  output  1  ff_count <= AEMPTY_TH.
rd_valid  output  1  RAM read data valid; 1 cycle after accepted read.
ovf_err  output  1  sticky overflow flag.
udf_err  output  1  sticky underflow flag.
frame_done  output  1  one-cycle pulse after FRAME_PIX-th accepted read.

Behaviour:
- Priority per edge: rst > ff_clr > normal operation.
- Reset/clear values: wptr=0, rptr=0, ff_count=0, rd_valid=0, ovf_err=0, udf_err=0, frame_done=0, internal read counter=0; hence almost_empty=1, almost_full=0 (AFULL_TH>0).
- Internal full/empty from own registers: full = (wptr MSBs differ) & (low bits equal); empty = wptr == rptr.
- Accepted write: wr_ok = ff_we & ~full. Accepted read: rd_ok = ff_re & ~empty. Strobes violating full/empty are ignored (defensive; status logic should already gate them).
- wptr += 1 on wr_ok, rptr += 1 on rd_ok; modulo 2^(ADDR_WIDTH+1), wrap bit toggles when low bits roll from all-ones to 0.
- ff_count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither. Invariant: ff_count == (wptr - rptr) mod 2^(ADDR_WIDTH+1).
- Pointers, count and flags update on the edge where the strobe is sampled; new values visible next cycle. almost_full/almost_empty are combinational compares on registered ff_count.
- rd_valid <= rd_ok (one-cycle synchronous RAM read latency, raddr presented in the strobe cycle).
- ovf_err set when ff_en & ff_push_pop & full, or ff_we & full; udf_err set when ff_en & ~ff_push_pop & empty, or ff_re & empty. Both hold until rst/ff_clr.
- Frame counter (32-bit) increments on rd_ok; when rd_ok and counter == FRAME_PIX-1: counter <= 0, frame_done <= 1 next cycle; otherwise frame_done <= 0.
- Full-to-empty and empty-to-full transitions need no extra cycles; a write in the cycle after reaching full is rejected.
- rst/ff_clr mid-stream discards all content; an in-flight rd_valid for a read accepted in the same cycle as rst is dropped (rd_valid=0 next cycle).

Test Plan:
(ADDR_WIDTH=4, AFULL_TH=14, AEMPTY_TH=2, FRAME_PIX=16)
- Reset: rst high 2 cycles -> wptr=0, rptr=0, ff_count=0, almost_empty=1, almost_full=0, rd_valid=0, errors=0.
- Fill: 16 cycles ff_we=1 -> ff_count=16, wptr=5'b10000, waddr=0, full; almost_full=1 from count 14; 17th ff_we ignored, wptr unchanged, ovf_err=1.
- Drain: from full, 16 cycles ff_re=1 -> rd_valid high cycles 2..17, rptr=5'b10000, ff_count=0; frame_done pulses one cycle after the 16th read; extra ff_en=1,ff_push_pop=0 -> udf_err=1, rptr unchanged.
- Simultaneous: count=5, ff_we=ff_re=1 for 3 cycles -> both pointers +3, ff_count stays 5, rd_valid=1 each following cycle.
- Wrap: 40 alternating write/read pairs -> pointer MSB toggles at 16 and 32, ff_count never exceeds 1, no error flags.
- Clear mid-operation: count=9, ovf_err=1, assert ff_clr with ff_we=1 -> next cycle all state at reset values, write not counted.
